// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler
//
// Shares one sprite line engine among NSPR sprite slots. On each line
// pulse the scheduler walks the slots in index order, one slot per cycle.
// Each enabled slot whose bitmap covers the current screen row is handed to
// the engine through a start/done handshake. At most MAX_ACT slots are
// issued per line. A visible slot that is skipped because the per-line
// budget is used up raises a sticky overflow flag.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   line          start-of-active-line pulse; restarts the scan in any state
//   sy            signed screen row, captured on the line pulse
//   spr_x_flat    packed signed sprite X, slot i at [i*CORDW +: CORDW]
//   spr_y_flat    packed signed sprite Y, same packing
//   spr_en        per-slot enable
//   eng_start     one-cycle start pulse to the engine
//   eng_id        slot index of the issued job
//   eng_sprx      X of the issued slot
//   eng_row       bitmap row of the issued slot
//   eng_abort     one-cycle pulse cancelling an in-flight engine job
//   eng_done      engine finished its current job (one-cycle pulse)
//   busy          scheduler is not idle
//   n_served      number of slots issued on this line
//   overflow      a visible, enabled slot was skipped on this line
//   line_done     one-cycle pulse when the scan of all slots completes
module sprite_line_scheduler #(
  parameter int CORDW      = 16,
  parameter int NSPR       = 4,
  parameter int MAX_ACT    = 2,
  parameter int SPR_HEIGHT = 8,
  parameter int SPR_SCALE  = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            line,
  input  logic signed [CORDW-1:0]         sy,
  input  logic [NSPR*CORDW-1:0]           spr_x_flat,
  input  logic [NSPR*CORDW-1:0]           spr_y_flat,
  input  logic [NSPR-1:0]                 spr_en,
  output logic                            eng_start,
  output logic [$clog2(NSPR)-1:0]         eng_id,
  output logic signed [CORDW-1:0]         eng_sprx,
  output logic [$clog2(SPR_HEIGHT)-1:0]   eng_row,
  output logic                            eng_abort,
  input  logic                            eng_done,
  output logic                            busy,
  output logic [$clog2(MAX_ACT+1)-1:0]    n_served,
  output logic                            overflow,
  output logic                            line_done
);

  localparam int IDW  = $clog2(NSPR);
  localparam int ROWW = $clog2(SPR_HEIGHT);
  localparam int NSW  = $clog2(MAX_ACT + 1);

  localparam logic [IDW-1:0]          LAST_IDX = IDW'(NSPR - 1);
  localparam logic [NSW-1:0]          MAX_CNT  = NSW'(MAX_ACT);
  localparam logic signed [CORDW-1:0] HEIGHT_C = CORDW'(SPR_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Source row of the sprite bitmap hit by screen row row_sy. The subtraction
  // wraps at CORDW bits and the scale divide is an arithmetic shift, so rows
  // above the sprite stay negative and are rejected by the sign test.
  function automatic logic signed [CORDW-1:0] row_diff(
    input logic signed [CORDW-1:0] row_sy,
    input logic signed [CORDW-1:0] row_y
  );
    logic signed [CORDW-1:0] d;
    d = row_sy - row_y;
    return d >>> SPR_SCALE;
  endfunction

  state_t                  state_r, state_nx;
  logic [IDW-1:0]          idx_r, idx_nx;
  logic signed [CORDW-1:0] sy_r, sy_nx;
  logic [NSW-1:0]          n_served_r, n_served_nx;
  logic                    overflow_r, overflow_nx;
  logic                    eng_start_r, eng_start_nx;
  logic                    eng_abort_r, eng_abort_nx;
  logic [IDW-1:0]          eng_id_r, eng_id_nx;
  logic signed [CORDW-1:0] eng_sprx_r, eng_sprx_nx;
  logic [ROWW-1:0]         eng_row_r, eng_row_nx;
  logic                    line_done_r, line_done_nx;
  logic                    busy_r, busy_nx;

  logic signed [CORDW-1:0] spr_x_s [NSPR];
  logic signed [CORDW-1:0] spr_y_s [NSPR];
  logic signed [CORDW-1:0] sel_x_s;
  logic signed [CORDW-1:0] sel_y_s;
  logic                    sel_en_s;
  logic signed [CORDW-1:0] diff_s;
  logic                    vis_s;
  logic                    last_s;
  logic                    full_s;

  for (genvar g = 0; g < NSPR; g++) begin : g_unpack
    assign spr_x_s[g] = spr_x_flat[g*CORDW +: CORDW];
    assign spr_y_s[g] = spr_y_flat[g*CORDW +: CORDW];
  end

  // Positions are read live for the slot under evaluation.
  assign sel_x_s  = spr_x_s[idx_r];
  assign sel_y_s  = spr_y_s[idx_r];
  assign sel_en_s = spr_en[idx_r];
  assign diff_s   = row_diff(sy_r, sel_y_s);
  assign vis_s    = sel_en_s && !diff_s[CORDW-1] && (diff_s < HEIGHT_C);
  assign last_s   = (idx_r == LAST_IDX);
  assign full_s   = (n_served_r == MAX_CNT);

  // Next-state and next-output logic; the line pulse overrides every state.
  always_comb begin
    state_nx     = state_r;
    idx_nx       = idx_r;
    sy_nx        = sy_r;
    n_served_nx  = n_served_r;
    overflow_nx  = overflow_r;
    eng_start_nx = 1'b0;
    eng_abort_nx = 1'b0;
    eng_id_nx    = eng_id_r;
    eng_sprx_nx  = eng_sprx_r;
    eng_row_nx   = eng_row_r;
    line_done_nx = 1'b0;

    if (line) begin
      sy_nx        = sy;
      idx_nx       = {IDW{1'b0}};
      n_served_nx  = {NSW{1'b0}};
      overflow_nx  = 1'b0;
      state_nx     = ST_SCAN;
      // Only a job actually in flight needs cancelling.
      eng_abort_nx = (state_r == ST_WAIT);
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx = ST_IDLE;
        end
        ST_SCAN: begin
          if (vis_s && !full_s) begin
            eng_id_nx    = idx_r;
            eng_sprx_nx  = sel_x_s;
            eng_row_nx   = diff_s[ROWW-1:0];
            eng_start_nx = 1'b1;
            n_served_nx  = n_served_r + NSW'(1);
            state_nx     = ST_WAIT;
          end else begin
            if (vis_s) begin
              overflow_nx = 1'b1;
            end else begin
              overflow_nx = overflow_r;
            end
            if (last_s) begin
              state_nx     = ST_IDLE;
              line_done_nx = 1'b1;
            end else begin
              idx_nx   = idx_r + IDW'(1);
              state_nx = ST_SCAN;
            end
          end
        end
        ST_WAIT: begin
          // Done may coincide with the start cycle; it is accepted either way.
          if (eng_done) begin
            if (last_s) begin
              state_nx     = ST_IDLE;
              line_done_nx = 1'b1;
            end else begin
              idx_nx   = idx_r + IDW'(1);
              state_nx = ST_SCAN;
            end
          end else begin
            state_nx = ST_WAIT;
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end

    busy_nx = (state_nx != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IDW{1'b0}};
      sy_r        <= {CORDW{1'b0}};
      n_served_r  <= {NSW{1'b0}};
      overflow_r  <= 1'b0;
      eng_start_r <= 1'b0;
      eng_abort_r <= 1'b0;
      eng_id_r    <= {IDW{1'b0}};
      eng_sprx_r  <= {CORDW{1'b0}};
      eng_row_r   <= {ROWW{1'b0}};
      line_done_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx;
      idx_r       <= idx_nx;
      sy_r        <= sy_nx;
      n_served_r  <= n_served_nx;
      overflow_r  <= overflow_nx;
      eng_start_r <= eng_start_nx;
      eng_abort_r <= eng_abort_nx;
      eng_id_r    <= eng_id_nx;
      eng_sprx_r  <= eng_sprx_nx;
      eng_row_r   <= eng_row_nx;
      line_done_r <= line_done_nx;
      busy_r      <= busy_nx;
    end
  end

  assign eng_start = eng_start_r;
  assign eng_abort = eng_abort_r;
  assign eng_id    = eng_id_r;
  assign eng_sprx  = eng_sprx_r;
  assign eng_row   = eng_row_r;
  assign busy      = busy_r;
  assign n_served  = n_served_r;
  assign overflow  = overflow_r;
  assign line_done = line_done_r;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler (NSPR=4, MAX_ACT=2,
// SPR_HEIGHT=8). A table of line scenarios is applied in a loop; each
// scenario pushes its expected engine jobs onto a scoreboard queue that is
// popped whenever eng_start is seen. Hand-written sequences cover abort,
// reset during a job and the 2x vertical scale (second instance).
module tb_sprite_line_scheduler;

  localparam int CORDW = 16;

  logic              clk;
  logic              rst;
  logic              line;
  logic [CORDW-1:0]  sy;
  logic [63:0]       spr_x_flat;
  logic [63:0]       spr_y_flat;
  logic [3:0]        spr_en;
  logic              eng_start, eng_abort, eng_done, busy, overflow, line_done;
  logic [1:0]        eng_id;
  logic [CORDW-1:0]  eng_sprx;
  logic [2:0]        eng_row;
  logic [1:0]        n_served;

  logic              eng_start1, eng_abort1, busy1, overflow1, line_done1;
  logic [1:0]        eng_id1;
  logic [CORDW-1:0]  eng_sprx1;
  logic [2:0]        eng_row1;
  logic [1:0]        n_served1;

  sprite_line_scheduler #(
    .CORDW(16), .NSPR(4), .MAX_ACT(2), .SPR_HEIGHT(8), .SPR_SCALE(0)
  ) dut (
    .clk(clk), .rst(rst), .line(line), .sy(sy),
    .spr_x_flat(spr_x_flat), .spr_y_flat(spr_y_flat), .spr_en(spr_en),
    .eng_start(eng_start), .eng_id(eng_id), .eng_sprx(eng_sprx),
    .eng_row(eng_row), .eng_abort(eng_abort), .eng_done(eng_done),
    .busy(busy), .n_served(n_served), .overflow(overflow),
    .line_done(line_done)
  );

  // Scale-2x instance; its engine finishes in the same cycle it is started.
  sprite_line_scheduler #(
    .CORDW(16), .NSPR(4), .MAX_ACT(2), .SPR_HEIGHT(8), .SPR_SCALE(1)
  ) dut1 (
    .clk(clk), .rst(rst), .line(line), .sy(sy),
    .spr_x_flat(spr_x_flat), .spr_y_flat(spr_y_flat), .spr_en(spr_en),
    .eng_start(eng_start1), .eng_id(eng_id1), .eng_sprx(eng_sprx1),
    .eng_row(eng_row1), .eng_abort(eng_abort1), .eng_done(eng_start1),
    .busy(busy1), .n_served(n_served1), .overflow(overflow1),
    .line_done(line_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int sprx;
    int row;
    int cyc;
  } exp_t;

  typedef struct {
    int          sy;
    logic [63:0] yf;
    logic [3:0]  en;
    int          d;
    int          n_exp;
    int          ovf_exp;
    int          ld_exp;
  } vec_t;

  exp_t q[$];
  vec_t tbl[10];

  int nchecks = 0;
  int nerrs   = 0;
  int cyc     = 0;
  int ld_cyc  = -1;
  int ab_cyc  = -1;
  int ab_cnt  = 0;
  int done_dly = 3;
  int cnt     = 0;
  int s1_cnt  = 0;
  int s1_row  = -1;
  int s1_cyc  = -1;
  int base    = 0;
  logic [63:0] xf;

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One clock: sample outputs mid-cycle, pop scoreboard, run the engine model.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (eng_start) begin
      if (q.size() == 0) begin
        check("unexpected_start_id", int'(eng_id), -1);
      end else begin
        e = q.pop_front();
        check("start_id", int'(eng_id), e.id);
        check("start_sprx", int'($signed(eng_sprx)), e.sprx);
        check("start_row", int'(eng_row), e.row);
        check("start_cycle", cyc, e.cyc);
      end
    end
    if (line_done) ld_cyc = cyc;
    if (eng_abort) begin
      ab_cnt++;
      ab_cyc = cyc;
    end
    if (eng_start1) begin
      s1_cnt++;
      s1_row = int'(eng_row1);
      s1_cyc = cyc;
    end
    eng_done = 1'b0;
    if (eng_abort) begin
      cnt = 0;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) eng_done = 1'b1;
    end
    if (eng_start) begin
      if (done_dly == 0) eng_done = 1'b1;
      else if (done_dly > 0) cnt = done_dly;
    end
  endtask

  task automatic pulse_line(input int sy_v);
    sy   = 16'(sy_v);
    line = 1'b1;
    tick();
    line = 1'b0;
  endtask

  // Reference: walk the slots, issue the first two visible ones, and time
  // each start from the cycle the line pulse was driven.
  task automatic push_model(input int sy_v, input logic [63:0] yf,
                            input logic [3:0] en, input int d, input int b);
    int t, n, y, x, diff;
    exp_t e;
    t = 1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      y = int'($signed(yf[i*16 +: 16]));
      x = int'($signed(xf[i*16 +: 16]));
      diff = sy_v - y;
      if (en[i] && diff >= 0 && diff < 8 && n < 2) begin
        e.id = i; e.sprx = x; e.row = diff; e.cyc = b + t + 1;
        q.push_back(e);
        n++;
        t = t + 2 + d;
      end else begin
        t = t + 1;
      end
    end
  endtask

  task automatic wait_line_done();
    for (int k = 0; k < 80 && ld_cyc < 0; k++) tick();
  endtask

  task automatic run_line(input string nm, input vec_t v);
    q.delete();
    done_dly   = v.d;
    ld_cyc     = -1;
    spr_y_flat = v.yf;
    spr_en     = v.en;
    base       = cyc;
    push_model(v.sy, v.yf, v.en, v.d, base);
    pulse_line(v.sy);
    wait_line_done();
    check({nm, "_line_done_cycle"}, ld_cyc - base, v.ld_exp);
    check({nm, "_n_served"}, int'(n_served), v.n_exp);
    check({nm, "_overflow"}, int'(overflow), v.ovf_exp);
    check({nm, "_busy_end"}, int'(busy), 0);
    check({nm, "_jobs_missing"}, q.size(), 0);
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; line = 1'b0; sy = '0; eng_done = 1'b0;
    xf = pack4(100, 110, 120, -40);
    spr_x_flat = xf;
    spr_y_flat = pack4(100, 100, 100, 100);
    spr_en = 4'b0000;

    tbl[0] = '{50, pack4(100, 100, 100, 100), 4'b1111, 3, 0, 0, 5};
    tbl[1] = '{20, pack4(100, 15, 100, 20),   4'b1010, 3, 2, 0, 13};
    tbl[2] = '{20, pack4(20, 18, 16, 14),     4'b1111, 3, 2, 1, 13};
    tbl[3] = '{20, pack4(100, 100, 17, 100),  4'b1111, 3, 1, 0, 9};
    tbl[4] = '{20, pack4(13, 100, 100, 100),  4'b0001, 3, 1, 0, 9};
    tbl[5] = '{20, pack4(12, 100, 100, 100),  4'b0001, 3, 0, 0, 5};
    tbl[6] = '{20, pack4(21, 100, 100, 100),  4'b0001, 3, 0, 0, 5};
    tbl[7] = '{-3, pack4(100, -2, 100, -10),  4'b1010, 3, 1, 0, 9};
    tbl[8] = '{20, pack4(20, 19, 100, 100),   4'b0011, 0, 2, 0, 7};
    tbl[9] = '{20, pack4(20, 100, 100, 100),  4'b0000, 3, 0, 0, 5};

    tick(); tick(); tick();
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_eng_start", int'(eng_start), 0);
    check("rst_eng_abort", int'(eng_abort), 0);
    check("rst_eng_id", int'(eng_id), 0);
    check("rst_eng_sprx", int'(eng_sprx), 0);
    check("rst_eng_row", int'(eng_row), 0);
    check("rst_n_served", int'(n_served), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_line_done", int'(line_done), 0);
    tick();

    for (int i = 0; i < 10; i++) begin
      run_line($sformatf("vec%0d", i), tbl[i]);
    end

    // Line pulse during an in-flight job: abort, then re-issue slot 0.
    q.delete(); ab_cnt = 0; ab_cyc = -1; ld_cyc = -1;
    done_dly = -1;
    spr_y_flat = pack4(20, 100, 100, 100);
    spr_en = 4'b0001;
    base = cyc;
    q.push_back('{0, 100, 0, base + 2});
    pulse_line(20);
    tick(); tick(); tick();
    check("abort_pre_none", ab_cnt, 0);
    check("abort_pre_busy", int'(busy), 1);
    done_dly = 3;
    base = cyc;
    q.push_back('{0, 100, 0, base + 2});
    pulse_line(20);
    wait_line_done();
    check("abort_cycle", ab_cyc - base, 1);
    check("abort_count", ab_cnt, 1);
    check("abort_line_done_cycle", ld_cyc - base, 9);
    check("abort_n_served", int'(n_served), 1);
    check("abort_jobs_missing", q.size(), 0);
    tick();

    // Reset while waiting on slot 2's job.
    q.delete(); ab_cnt = 0;
    done_dly = -1;
    spr_y_flat = pack4(100, 100, 17, 100);
    spr_en = 4'b0100;
    base = cyc;
    q.push_back('{2, 120, 3, base + 4});
    pulse_line(20);
    for (int k = 0; k < 4; k++) tick();
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_eng_id", int'(eng_id), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_eng_id", int'(eng_id), 0);
    check("mid_rst_eng_sprx", int'(eng_sprx), 0);
    check("mid_rst_eng_row", int'(eng_row), 0);
    check("mid_rst_n_served", int'(n_served), 0);
    check("mid_rst_eng_abort", int'(eng_abort), 0);
    tick(); tick(); tick();
    check("mid_rst_no_abort", ab_cnt, 0);
    check("mid_rst_jobs_missing", q.size(), 0);
    cnt = 0;

    // 2x scale instance: y=5 at sy=20 gives source row 7; y=4 falls off.
    s1_cnt = 0; s1_row = -1; s1_cyc = -1;
    base = cyc;
    run_line("scale_y5", '{20, pack4(5, 100, 100, 100), 4'b0001, 3, 0, 0, 5});
    check("scale_y5_count", s1_cnt, 1);
    check("scale_y5_row", s1_row, 7);
    check("scale_y5_cycle", s1_cyc - base, 2);
    s1_cnt = 0;
    run_line("scale_y4", '{20, pack4(4, 100, 100, 100), 4'b0001, 3, 0, 0, 5});
    check("scale_y4_count", s1_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline scheduler that shares one sprite line engine (ROM fetch + pixel output) among NSPR sprite slots.
- On each `line` pulse it scans the slots in index order and finds those whose bitmap covers the current screen row.
- It hands each visible slot to the engine through a start/done handshake, one at a time, up to MAX_ACT slots per line.
- Sits between the game/position registers and the sprite engine; also flags lines with too many visible sprites.

Parameters:
- CORDW, 16, signed coordinate width (bits)
- NSPR, 4, number of sprite slots (>=2)
- MAX_ACT, 2, max sprites issued per line (1..NSPR)
- SPR_HEIGHT, 8, sprite bitmap height in source rows
- SPR_SCALE, 0, vertical scale shift: 0=1x, 1=2x, 2=4x

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- line  in  1  start-of-active-line pulse
- sy  in  CORDW  signed screen row; sampled on `line`
- spr_x_flat  in  NSPR*CORDW  signed sprite X; slot i at [i*CORDW +: CORDW]
- spr_y_flat  in  NSPR*CORDW  signed sprite Y; same packing
- spr_en  in  NSPR  per-slot enable
- eng_start  out  1  one-cycle start pulse to engine
- eng_id  out  clog2(NSPR)  slot index being issued
- eng_sprx  out  CORDW  X of issued slot
- eng_row  out  clog2(SPR_HEIGHT)  bitmap row for issued slot
- eng_abort  out  1  one-cycle pulse: cancel engine job
- eng_done  in  1  engine finished current job (one-cycle pulse)
- busy  out  1  state != IDLE
- n_served  out  clog2(MAX_ACT+1)  sprites issued on this line
- overflow  out  1  a visible, enabled slot was skipped this line
- line_done  out  1  one-cycle pulse when scan of all slots completes

Behaviour:
- Reset: state=IDLE. eng_start=0, eng_abort=0, eng_id=0, eng_sprx=0, eng_row=0, n_served=0, overflow=0, line_done=0. busy=0.
- Row math:
  - diff = (sy_r - spr_y[idx]) >>> SPR_SCALE, arithmetic shift, CORDW bits signed.
  - vis = spr_en[idx] && diff>=0 && diff<SPR_HEIGHT.
  - eng_row = diff[clog2(SPR_HEIGHT)-1:0].
- States: IDLE, SCAN, WAIT_DONE. All outputs are registered.
- `line` has priority over everything, in any state:
  - sy_r<=sy, idx<=0, n_served<=0, overflow<=0, state<=SCAN.
  - If the old state was WAIT_DONE, eng_abort pulses for 1 cycle.
  - Any eng_done in that cycle is ignored.
- IDLE: waits for `line`.
- SCAN (evaluates slot idx, one slot per cycle):
  - vis && n_served<MAX_ACT: latch eng_id=idx, eng_sprx, eng_row; eng_start<=1; n_served++; state<=WAIT_DONE.
  - vis && n_served==MAX_ACT: overflow<=1 (sticky until next `line`); advance.
  - !vis: advance.
  - Advance: if idx==NSPR-1, state<=IDLE and line_done pulses; else idx++.
- WAIT_DONE:
  - eng_start is high only in the first cycle; eng_id/sprx/row hold stable until eng_done.
  - eng_done is accepted in any WAIT_DONE cycle, including the eng_start cycle.
  - On eng_done: if idx==NSPR-1, go to IDLE and pulse line_done; else idx++ and go to SCAN.
- eng_done outside WAIT_DONE is ignored.
- Latency, `line` at edge T:
  - SCAN at T+1.
  - First eng_start is high at T+2 if slot 0 is visible.
  - Each invisible slot costs 1 cycle.
  - Line with no visible slots: line_done at T+1+NSPR.
- Sprite positions and enables are read live during SCAN; the caller keeps them stable for the line.
- Reset mid-operation: immediate return to reset values; no eng_abort pulse.

Test Plan:
- No visible slots (all spr_y=100, sy=50) -> eng_start never pulses; line_done pulse 5 cycles after `line`; n_served=0, overflow=0.
- sy=20; slot1 y=15; slot3 y=20 (others off); eng_done 3 cycles after each start:
  - First start: eng_id=1, eng_row=5.
  - Second start: eng_id=3, eng_row=0.
  - Result: n_served=2, line_done after slot 3's done.
- All 4 slots visible, MAX_ACT=2 -> slots 0 and 1 issued, overflow=1, n_served=2. Next `line` with only slot 2 visible -> overflow=0, eng_id=2.
- Boundary rows, sy=20:
  - y=13: row 7, issued.
  - y=12: diff=8, skipped.
  - y=21: diff=-1, skipped.
  - SPR_SCALE=1, y=5: diff=7, issued with row 7.
- `line` arrives during WAIT_DONE (slot 0 job) -> eng_abort 1 cycle; scan restarts at idx 0; eng_start for slot 0 re-issued 2 cycles after `line`.
- eng_done in the same cycle as eng_start -> accepted; next slot evaluated the following cycle. rst asserted mid-WAIT_DONE -> busy=0 next cycle, all outputs at reset values.
